// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - prioritised stall/flush/forwarding control for the 5-stage RV32I pipeline
module hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MD_LAT     = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] Rs1D,
  input  logic [REG_ADDR_W-1:0] Rs2D,
  input  logic [REG_ADDR_W-1:0] Rs1E,
  input  logic [REG_ADDR_W-1:0] Rs2E,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [REG_ADDR_W-1:0] RdM,
  input  logic [REG_ADDR_W-1:0] RdW,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemReadE,
  input  logic                  MemAccessM,
  input  logic                  MemReadyM,
  input  logic                  MulDivE,
  input  logic                  PCSrcE,
  output logic [1:0]            ForwardAE,
  output logic [1:0]            ForwardBE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  StallM,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  md_busy,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam int MD_W = (MD_LAT > 1) ? $clog2(MD_LAT) : 1;
  localparam logic [MD_W-1:0] MD_LAST = MD_W'(MD_LAT - 1);

  logic [MD_W-1:0] md_cnt;
  logic            mem_wait;
  logic            md_hold;
  logic            load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_W-1:0] rs,
    input logic [REG_ADDR_W-1:0] rd_m,
    input logic                  we_m,
    input logic [REG_ADDR_W-1:0] rd_w,
    input logic                  we_w
  );
    if (we_m && (rd_m != '0) && (rd_m == rs))      fwd_sel = 2'b10;
    else if (we_w && (rd_w != '0) && (rd_w == rs)) fwd_sel = 2'b01;
    else                                           fwd_sel = 2'b00;
  endfunction

  assign mem_wait = MemAccessM && !MemReadyM;
  assign md_hold  = MulDivE && (md_cnt != MD_LAST);
  assign load_use = MemReadE && (RdE != '0) && ((RdE == Rs1D) || (RdE == Rs2D));

  // Everything is forced quiet while reset is held, including forwarding.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    md_busy   = 1'b0;
    if (rst_n) begin
      ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
      ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
      md_busy   = md_hold;
      if (mem_wait) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
      end else if (md_hold) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (PCSrcE) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  // md_cnt wraps to 0 on the instruction's last cycle so a back-to-back op starts fresh.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (!MulDivE) begin
      md_cnt <= '0;
    end else if (!mem_wait) begin
      if (md_cnt == MD_LAST) md_cnt <= '0;
      else                   md_cnt <= md_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (StallF && !(&stall_cycles)) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RV32I core, replacing the single-cycle forwarding/stall unit. It combines the following behaviours into one prioritised set of stall and flush controls:
- M-over-W forwarding with x0 exclusion.
- Decode-stage load-use detection.
- Taken-branch flush.
- Data-memory wait-state freeze.
- A counter-based hold for a multi-cycle mul/div unit in Execute.

It also keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- MD_LAT, 4, cycles a mul/div instruction occupies Execute (≥1; 1 = no hold)
- CNT_W, 32, stall performance counter width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- Rs1D, Rs2D  in  REG_ADDR_W  source registers in Decode
- Rs1E, Rs2E, RdE  in  REG_ADDR_W  sources/destination in Execute
- RdM, RdW  in  REG_ADDR_W  destinations in Memory/Writeback
- RegWriteM, RegWriteW  in  1  destination write enables
- MemReadE  in  1  Execute instruction is a load
- MemAccessM  in  1  Memory-stage instruction accesses data memory
- MemReadyM  in  1  data memory completes this cycle
- MulDivE  in  1  Execute instruction is mul/div
- PCSrcE  in  1  taken branch/jump resolved in Execute
- ForwardAE, ForwardBE  out  2  00 register file, 01 ResultW, 10 ALUResultM
- StallF, StallD, StallE, StallM  out  1  hold stage register
- FlushD, FlushE, FlushM  out  1  clear stage register to bubble
- md_busy  out  1  mul/div hold in progress
- stall_cycles  out  CNT_W  cycles with StallF=1, saturating

## Operation
Forwarding (A; B identical with Rs2E):
- 10 if RegWriteM && RdM≠0 && RdM==Rs1E.
- Else 01 if RegWriteW && RdW≠0 && RdW==Rs1E.
- Else 00.
- Forwarding is combinational and always valid, including during stalls.

Hazard conditions:
- mem_wait = MemAccessM && !MemReadyM.
- md_hold = MulDivE && md_cnt ≠ MD_LAT−1.
- load_use = MemReadE && RdE≠0 && (RdE==Rs1D || RdE==Rs2D).

Resolution, highest priority first:
1. mem_wait: StallF=StallD=StallE=StallM=1; all flushes 0.
2. md_hold: StallF=StallD=StallE=1, FlushM=1 (bubble into Memory).
3. PCSrcE: FlushD=FlushE=1; load_use ignored.
4. load_use: StallF=StallD=1, FlushE=1.
5. Otherwise all outputs 0.

md_cnt (width ⌈log2 MD_LAT⌉, min 1):
- Increments when MulDivE && !mem_wait && md_cnt<MD_LAT−1.
- Returns to 0 when MulDivE && !mem_wait && md_cnt==MD_LAT−1.
- Holds during mem_wait.
- Forced to 0 when MulDivE=0.
- md_busy = md_hold.

stall_cycles:
- +1 on every cycle with StallF=1.
- Saturates at 2^CNT_W−1 and does not wrap.

## Timing
- Reset (rst_n low at posedge): md_cnt=0, stall_cycles=0. While rst_n is low, all Stall*/Flush* outputs=0, Forward*=00, md_busy=0. Reset mid-mul/div abandons the count.
- Hazard outputs are combinational from inputs and md_cnt; there is no added latency.
- Load-use costs exactly 1 bubble. The dependent instruction sees ForwardxE=01 from the load's Writeback on the following cycle.
- A mul/div instruction stays in Execute for exactly MD_LAT cycles (md_cnt 0..MD_LAT−1) plus any mem_wait cycles. It advances on the cycle md_cnt==MD_LAT−1.
- mem_wait overlapping md_hold: freeze wins. md_cnt does not advance, and FlushM=0.
- mem_wait with PCSrcE: no flush. The flush is applied on the first cycle mem_wait drops.
- Back-to-back mul/div: md_cnt returns to 0 as the first instruction leaves, and the second instruction starts counting at 0.

## Test plan
- Forwarding: RdM=RdW=Rs1E=5, RegWriteM=RegWriteW=1 → ForwardAE=10. With RdM=0=Rs1E → ForwardAE=00. With RegWriteM=0, RdW=Rs2E=7 → ForwardBE=01.
- Load-use: MemReadE=1, RdE=3, Rs2D=3 → one cycle of StallF=StallD=FlushE=1; stall_cycles 0→1. Same stimulus with PCSrcE=1 → FlushD=FlushE=1, StallF=0.
- Mul/div with MD_LAT=4: MulDivE held → StallE=1, FlushM=1, md_busy=1 for 3 cycles, then 0 on the 4th cycle. stall_cycles=3.
- Memory wait during mul/div: MemReadyM=0 for 2 cycles starting at md_cnt=1 → StallM=1, FlushM=0, md_cnt frozen at 1. Total Execute residency is 6 cycles.
- Saturation and reset: CNT_W=3 with 10 stall cycles → stall_cycles=7. Assert rst_n=0 mid-mul/div at md_cnt=2 → next cycle md_cnt=0, stall_cycles=0, all outputs 0.
